mmio_address_router: RTL

- Registered, handshaked address router between the CPU data port and the memory-mapped register slots plus data RAM.
- Low addresses map one-hot onto NUM_REGS register slots; the next RAM_DEPTH addresses map to RAM, which has a fixed read latency.
- Higher addresses return a bus error.
- Returns read data and a response strobe per transaction, handling one transaction at a time.

---
 rtl/mmio_pkg.sv | 33 +++
 rtl/mmio_onehot_decoder.sv | 21 ++
 rtl/mmio_address_router.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/mmio_pkg.sv
// Shared types and helpers for the MMIO address router: FSM states, default
// geometry and the region decode used on request acceptance.
package mmio_pkg;

    localparam int unsigned NUM_REGS_DEF  = 17;
    localparam int unsigned RAM_DEPTH_DEF = 1024;

    typedef enum logic [1:0] {
        IDLE,
        REG_ACC,
        RAM_WAIT,
        RESP
    } state_e;

    typedef enum logic [1:0] {
        REG,
        RAM,
        ERR
    } region_e;

    // Unsigned compares on the full request address; registers sit below RAM.
    function automatic region_e decode_region(input logic [31:0] addr,
                                              input int unsigned num_regs,
                                              input int unsigned ram_depth);
        if (addr < num_regs) begin
            return REG;
        end else if (addr < (num_regs + ram_depth)) begin
            return RAM;
        end
        return ERR;
    endfunction

endpackage

// File: rtl/mmio_onehot_decoder.sv
// Binary index to one-hot select with an enable; all zeros when disabled or
// when the index falls outside the output width.
module mmio_onehot_decoder #(
    parameter int unsigned OUT_W = 17,
    parameter int unsigned IN_W  = 5
) (
    input  logic              en_i,
    input  logic [IN_W-1:0]   idx_i,
    output logic [OUT_W-1:0]  onehot_o
);

    always_comb begin
        onehot_o = '0;
        for (int i = 0; i < OUT_W; i++) begin
            if (en_i && (idx_i == IN_W'(i))) begin
                onehot_o[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mmio_address_router.sv
// Registered, handshaked router from the CPU data port to register slots and
// a fixed-latency RAM; one transaction in flight, single-cycle response.
module mmio_address_router
    import mmio_pkg::*;
#(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned NUM_REGS    = NUM_REGS_DEF,
    parameter int unsigned RAM_DEPTH   = RAM_DEPTH_DEF,
    parameter int unsigned RAM_AW      = 10,
    parameter int unsigned RAM_LATENCY = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_we,
    input  logic [ADDR_W-1:0]           req_addr,
    input  logic [DATA_W-1:0]           req_wdata,
    output logic                        rsp_valid,
    output logic [DATA_W-1:0]           rsp_rdata,
    output logic                        rsp_err,
    output logic [NUM_REGS-1:0]         reg_sel,
    output logic                        reg_we,
    output logic [DATA_W-1:0]           reg_wdata,
    input  logic [NUM_REGS*DATA_W-1:0]  reg_rdata_flat,
    output logic                        ram_en,
    output logic                        ram_we,
    output logic [RAM_AW-1:0]           ram_addr,
    output logic [DATA_W-1:0]           ram_wdata,
    input  logic [DATA_W-1:0]           ram_rdata
);

    localparam int unsigned SEL_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int unsigned CNT_W = $clog2(RAM_LATENCY + 1);

    state_e                 state_q;
    region_e                region;
    logic [NUM_REGS-1:0]    sel_d;
    logic [DATA_W-1:0]      reg_rd_mux;
    logic [CNT_W-1:0]       cnt_q;
    logic                   we_q;

    logic                   req_ready_q;
    logic                   rsp_valid_q;
    logic [DATA_W-1:0]      rsp_rdata_q;
    logic                   rsp_err_q;
    logic [NUM_REGS-1:0]    reg_sel_q;
    logic                   reg_we_q;
    logic [DATA_W-1:0]      reg_wdata_q;
    logic                   ram_en_q;
    logic                   ram_we_q;
    logic [RAM_AW-1:0]      ram_addr_q;
    logic [DATA_W-1:0]      ram_wdata_q;

    assign region = decode_region(32'(req_addr), NUM_REGS, RAM_DEPTH);

    mmio_onehot_decoder #(
        .OUT_W (NUM_REGS),
        .IN_W  (SEL_W)
    ) u_sel_dec (
        .en_i     ((state_q == IDLE) && req_valid && (region == REG)),
        .idx_i    (SEL_W'(req_addr)),
        .onehot_o (sel_d)
    );

    // The held one-hot select doubles as the read-data mux control.
    always_comb begin
        reg_rd_mux = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (reg_sel_q[i]) begin
                reg_rd_mux = reg_rdata_flat[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            reg_sel_q   <= '0;
            reg_we_q    <= 1'b0;
            reg_wdata_q <= '0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
        end else begin
            // Strobes and the response are single-cycle pulses by default.
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            reg_sel_q   <= '0;
            reg_we_q    <= 1'b0;
            reg_wdata_q <= '0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;

            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        req_ready_q <= 1'b0;
                        we_q        <= req_we;
                        case (region)
                            REG: begin
                                state_q     <= REG_ACC;
                                reg_sel_q   <= sel_d;
                                reg_we_q    <= req_we;
                                reg_wdata_q <= req_wdata;
                            end
                            RAM: begin
                                state_q     <= RAM_WAIT;
                                cnt_q       <= CNT_W'(RAM_LATENCY);
                                ram_en_q    <= 1'b1;
                                ram_we_q    <= req_we;
                                ram_addr_q  <= RAM_AW'(req_addr - ADDR_W'(NUM_REGS));
                                ram_wdata_q <= req_wdata;
                            end
                            default: begin
                                state_q     <= RESP;
                                rsp_valid_q <= 1'b1;
                                rsp_err_q   <= 1'b1;
                            end
                        endcase
                    end
                end
                REG_ACC: begin
                    state_q     <= RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= we_q ? '0 : reg_rd_mux;
                end
                RAM_WAIT: begin
                    // Writes also run out the full latency so timing is uniform.
                    if (cnt_q == '0) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= we_q ? '0 : ram_rdata;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                RESP: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign reg_sel   = reg_sel_q;
    assign reg_we    = reg_we_q;
    assign reg_wdata = reg_wdata_q;
    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;

endmodule
